// File: rtl/tape_punch_dev.sv
// Device-side G-15 paper tape punch: timed punch cycle, PUNCH_SYNC handshake and a
// first-word-fall-through queue of punched frames. Optional blank-leader feed: TAPE_PUNCH_FEED_EN.
module tape_punch_dev #(
    parameter int CYCLE_CLKS = 6400,
    parameter int SYNC_CLKS  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLOCK,
    input  logic                          rst,
    input  logic                          PUNCH_SIGNAL,
    input  logic                          OB1,
    input  logic                          OB2,
    input  logic                          OB3,
    input  logic                          OB4,
    input  logic                          OB5,
    output logic                          PUNCH_SYNC,
    output logic                          PUNCHED_TAPE1,
    output logic                          PUNCHED_TAPE2,
    output logic                          PUNCHED_TAPE3,
    output logic                          PUNCHED_TAPE4,
    output logic                          PUNCHED_TAPE5,
    output logic [4:0]                    tape_data,
    output logic                          tape_valid,
    input  logic                          tape_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tape_full,
    output logic                          punch_busy
`ifdef TAPE_PUNCH_FEED_EN
    ,
    input  logic                          FEED
`endif
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int CNTW      = $clog2(CYCLE_CLKS) + 1;
    localparam int HOLD_CLKS = CYCLE_CLKS - SYNC_CLKS - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]      state_r, state_s;
    logic [CNTW-1:0] cnt_r, cnt_s;
    logic [4:0]      code_r, code_s;
    logic            feed_r, feed_s;
    logic [4:0]      punched_r, punched_s;
    logic            sync_r, sync_s;
    logic            busy_r, busy_s;

    logic [4:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_r, rd_ptr_s;
    logic [AW-1:0]   wr_ptr_r, wr_ptr_s;
    logic [CW-1:0]   count_r, count_s;
    logic [CW-1:0]   after_pop_s;
    logic [4:0]      data_r, data_s;
    logic            valid_r, valid_s;
    logic            full_r, full_s;
    logic            push_s, pop_s;
    logic [4:0]      ob_s;

    assign ob_s = {OB5, OB4, OB3, OB2, OB1};

    // Punch-cycle sequencer: capture in IDLE, timed SYNC then HOLD phases.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        code_s    = code_r;
        feed_s    = feed_r;
        punched_s = punched_r;
        case (state_r)
            ST_IDLE: begin
                if (PUNCH_SIGNAL && !full_r) begin
                    state_s   = ST_SYNC;
                    cnt_s     = {CNTW{1'b0}};
                    code_s    = ob_s;
                    feed_s    = 1'b0;
                    punched_s = ob_s;
                end
`ifdef TAPE_PUNCH_FEED_EN
                // Blank leader: a silent cycle that still queues an all-zero frame.
                else if (FEED && !full_r) begin
                    state_s   = ST_SYNC;
                    cnt_s     = {CNTW{1'b0}};
                    code_s    = 5'b00000;
                    feed_s    = 1'b1;
                    punched_s = 5'b00000;
                end
`endif
                else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (cnt_r == CNTW'(SYNC_CLKS - 1)) begin
                    state_s = ST_HOLD;
                    cnt_s   = {CNTW{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNTW'(HOLD_CLKS - 1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNTW{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNTW{1'b0}};
            end
        endcase
        sync_s = (state_s == ST_SYNC) && !feed_s;
        busy_s = (state_s != ST_IDLE);
    end

    // Queue bookkeeping; the head frame is precomputed so tape_data is a plain register.
    always_comb begin
        push_s      = (state_r == ST_SYNC) && (cnt_r == {CNTW{1'b0}});
        pop_s       = valid_r && tape_ready;
        rd_ptr_s    = pop_s  ? rd_ptr_r + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_r;
        wr_ptr_s    = push_s ? wr_ptr_r + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_r;
        after_pop_s = count_r - CW'(pop_s);
        count_s     = after_pop_s + CW'(push_s);
        if (count_s == {CW{1'b0}}) begin
            data_s = 5'b00000;
        end else if (after_pop_s == {CW{1'b0}}) begin
            // Only the frame being pushed right now remains: it bypasses the memory.
            data_s = code_r;
        end else begin
            data_s = mem_r[rd_ptr_s];
        end
        valid_s = (count_s != {CW{1'b0}});
        full_s  = (count_s == CW'(FIFO_DEPTH));
    end

    // Frame storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge CLOCK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= code_r;
        end
    end

    // State, queue pointers and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNTW{1'b0}};
            code_r    <= 5'b00000;
            feed_r    <= 1'b0;
            punched_r <= 5'b00000;
            sync_r    <= 1'b0;
            busy_r    <= 1'b0;
            rd_ptr_r  <= {AW{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            data_r    <= 5'b00000;
            valid_r   <= 1'b0;
            full_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            code_r    <= code_s;
            feed_r    <= feed_s;
            punched_r <= punched_s;
            sync_r    <= sync_s;
            busy_r    <= busy_s;
            rd_ptr_r  <= rd_ptr_s;
            wr_ptr_r  <= wr_ptr_s;
            count_r   <= count_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            full_r    <= full_s;
        end
    end

    assign PUNCH_SYNC    = sync_r;
    assign PUNCHED_TAPE1 = punched_r[0];
    assign PUNCHED_TAPE2 = punched_r[1];
    assign PUNCHED_TAPE3 = punched_r[2];
    assign PUNCHED_TAPE4 = punched_r[3];
    assign PUNCHED_TAPE5 = punched_r[4];
    assign tape_data     = data_r;
    assign tape_valid    = valid_r;
    assign fifo_count    = count_r;
    assign tape_full     = full_r;
    assign punch_busy    = busy_r;

endmodule

// File: tb/tb_tape_punch_dev.sv
// Directed self-checking bench for tape_punch_dev (CYCLE_CLKS=20, SYNC_CLKS=4, FIFO_DEPTH=16).
module tb_tape_punch_dev;

    logic       clk_s = 1'b0;
    logic       rst_s;
    logic       punch_signal_s;
    logic [4:0] ob_s;
    logic       sync_s;
    logic [4:0] punched_s;
    logic [4:0] tape_data_s;
    logic       tape_valid_s;
    logic       tape_ready_s;
    logic [4:0] fifo_count_s;
    logic       tape_full_s;
    logic       punch_busy_s;
`ifdef TAPE_PUNCH_FEED_EN
    logic       feed_s;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tape_punch_dev #(.CYCLE_CLKS(20), .SYNC_CLKS(4), .FIFO_DEPTH(16)) dut (
        .CLOCK         (clk_s),
        .rst           (rst_s),
        .PUNCH_SIGNAL  (punch_signal_s),
        .OB1           (ob_s[0]),
        .OB2           (ob_s[1]),
        .OB3           (ob_s[2]),
        .OB4           (ob_s[3]),
        .OB5           (ob_s[4]),
        .PUNCH_SYNC    (sync_s),
        .PUNCHED_TAPE1 (punched_s[0]),
        .PUNCHED_TAPE2 (punched_s[1]),
        .PUNCHED_TAPE3 (punched_s[2]),
        .PUNCHED_TAPE4 (punched_s[3]),
        .PUNCHED_TAPE5 (punched_s[4]),
        .tape_data     (tape_data_s),
        .tape_valid    (tape_valid_s),
        .tape_ready    (tape_ready_s),
        .fifo_count    (fifo_count_s),
        .tape_full     (tape_full_s),
        .punch_busy    (punch_busy_s)
`ifdef TAPE_PUNCH_FEED_EN
        ,
        .FEED          (feed_s)
`endif
    );

    always #5 clk_s = ~clk_s;

    task automatic step();
        @(negedge clk_s);
        cyc++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [4:0] codes [3];
    int         rise_cyc [3];
    int         n_rise;
    int         n_sync;
    int         fall_idx;
    logic       prev_sync;

    initial begin
        codes[0] = 5'h01; codes[1] = 5'h02; codes[2] = 5'h1F;
        rst_s = 1'b0; punch_signal_s = 1'b0; ob_s = 5'h00; tape_ready_s = 1'b0;
`ifdef TAPE_PUNCH_FEED_EN
        feed_s = 1'b0;
`endif
        step(); step();
        check_eq("rst_sync",    32'(sync_s),       32'd0);
        check_eq("rst_punched", 32'(punched_s),    32'd0);
        check_eq("rst_valid",   32'(tape_valid_s), 32'd0);
        check_eq("rst_data",    32'(tape_data_s),  32'd0);
        check_eq("rst_count",   32'(fifo_count_s), 32'd0);
        check_eq("rst_full",    32'(tape_full_s),  32'd0);
        check_eq("rst_busy",    32'(punch_busy_s), 32'd0);
        rst_s = 1'b1;
        step();

        // 1: single punch of 10110
        punch_signal_s = 1'b1; ob_s = 5'b10110;
        step();
        punch_signal_s = 1'b0; ob_s = 5'h00;
        check_eq("t1_sync_first", 32'(sync_s),       32'd1);
        check_eq("t1_punched",    32'(punched_s),    32'h16);
        check_eq("t1_valid_pre",  32'(tape_valid_s), 32'd0);
        n_sync = 1; fall_idx = 0;
        for (int i = 1; i <= 21; i++) begin
            step();
            if (sync_s) n_sync++;
            if (!punch_busy_s && fall_idx == 0) fall_idx = i;
            if (i == 1) begin
                check_eq("t1_valid", 32'(tape_valid_s), 32'd1);
                check_eq("t1_data",  32'(tape_data_s),  32'h16);
                check_eq("t1_count", 32'(fifo_count_s), 32'd1);
            end
            if (i == 4) check_eq("t1_sync_end", 32'(sync_s), 32'd0);
        end
        check_eq("t1_sync_len",  32'(n_sync),   32'd4);
        check_eq("t1_busy_fall", 32'(fall_idx), 32'd19);
        tape_ready_s = 1'b1;
        step();
        tape_ready_s = 1'b0;
        check_eq("t1_pop_count", 32'(fifo_count_s), 32'd0);
        check_eq("t1_pop_valid", 32'(tape_valid_s), 32'd0);
        check_eq("t1_pop_data",  32'(tape_data_s),  32'd0);

        // 2: back-to-back cycles with OB changed on each sync rise
        punch_signal_s = 1'b1; ob_s = codes[0];
        n_rise = 0; prev_sync = 1'b0;
        for (int i = 0; i < 80 && n_rise < 3; i++) begin
            step();
            if (sync_s && !prev_sync) begin
                rise_cyc[n_rise] = cyc;
                n_rise++;
                if (n_rise < 3) ob_s = codes[n_rise];
                else punch_signal_s = 1'b0;
            end
            prev_sync = sync_s;
        end
        punch_signal_s = 1'b0;
        check_eq("t2_rises", 32'(n_rise), 32'd3);
        if (n_rise == 3) begin
            check_eq("t2_gap1", 32'(rise_cyc[1] - rise_cyc[0]), 32'd20);
            check_eq("t2_gap2", 32'(rise_cyc[2] - rise_cyc[1]), 32'd20);
        end
        for (int i = 0; i < 22; i++) step();
        check_eq("t2_count", 32'(fifo_count_s), 32'd3);
        tape_ready_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq("t2_pop_data", 32'(tape_data_s), 32'(codes[k]));
            step();
        end
        tape_ready_s = 1'b0;
        check_eq("t2_empty", 32'(fifo_count_s), 32'd0);

        // 3: fill the queue, 17th request stalls until a pop
        punch_signal_s = 1'b1; ob_s = 5'h0A;
        n_rise = 0; prev_sync = 1'b0;
        for (int i = 0; i < 380; i++) begin
            step();
            if (sync_s && !prev_sync) n_rise++;
            prev_sync = sync_s;
        end
        check_eq("t3_rises",      32'(n_rise),       32'd16);
        check_eq("t3_count",      32'(fifo_count_s), 32'd16);
        check_eq("t3_full",       32'(tape_full_s),  32'd1);
        check_eq("t3_stall_busy", 32'(punch_busy_s), 32'd0);
        check_eq("t3_stall_sync", 32'(sync_s),       32'd0);
        tape_ready_s = 1'b1;
        step();
        tape_ready_s = 1'b0;
        check_eq("t3_pop_count", 32'(fifo_count_s), 32'd15);
        check_eq("t3_pop_full",  32'(tape_full_s),  32'd0);
        step();
        check_eq("t3_recap_sync", 32'(sync_s), 32'd1);
        punch_signal_s = 1'b0;
        step();
        check_eq("t3_refill_count", 32'(fifo_count_s), 32'd16);
        check_eq("t3_refill_full",  32'(tape_full_s),  32'd1);

        // 4: push and pop on the same edge at count 1
        for (int i = 0; i < 20; i++) step();
        tape_ready_s = 1'b1;
        for (int i = 0; i < 15; i++) step();
        tape_ready_s = 1'b0;
        check_eq("t4_pre_count", 32'(fifo_count_s), 32'd1);
        punch_signal_s = 1'b1; ob_s = 5'h15;
        step();
        punch_signal_s = 1'b0; tape_ready_s = 1'b1;
        step();
        tape_ready_s = 1'b0;
        check_eq("t4_count", 32'(fifo_count_s), 32'd1);
        check_eq("t4_data",  32'(tape_data_s),  32'h15);
        for (int i = 0; i < 20; i++) step();
        tape_ready_s = 1'b1;
        step();
        tape_ready_s = 1'b0;
        check_eq("t4_empty", 32'(fifo_count_s), 32'd0);

        // 5: reset during the second SYNC clock with 3 frames queued
        punch_signal_s = 1'b1; ob_s = 5'h03;
        n_rise = 0; prev_sync = 1'b0;
        for (int i = 0; i < 80 && n_rise < 3; i++) begin
            step();
            if (sync_s && !prev_sync) n_rise++;
            prev_sync = sync_s;
        end
        punch_signal_s = 1'b0;
        check_eq("t5_rises", 32'(n_rise), 32'd3);
        step();
        check_eq("t5_pre_count", 32'(fifo_count_s), 32'd3);
        rst_s = 1'b0;
        step();
        rst_s = 1'b1;
        check_eq("t5_sync",    32'(sync_s),       32'd0);
        check_eq("t5_count",   32'(fifo_count_s), 32'd0);
        check_eq("t5_punched", 32'(punched_s),    32'd0);
        check_eq("t5_busy",    32'(punch_busy_s), 32'd0);
        check_eq("t5_valid",   32'(tape_valid_s), 32'd0);
        step();

`ifdef TAPE_PUNCH_FEED_EN
        // 6: blank leader feed, then a real punch with FEED still high
        feed_s = 1'b1;
        n_sync = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (sync_s) n_sync++;
        end
        feed_s = 1'b0;
        check_eq("t6_feed_count", 32'(fifo_count_s), 32'd3);
        check_eq("t6_feed_sync",  32'(n_sync),       32'd0);
        check_eq("t6_feed_data",  32'(tape_data_s),  32'd0);
        check_eq("t6_feed_valid", 32'(tape_valid_s), 32'd1);
        step();
        feed_s = 1'b1; punch_signal_s = 1'b1; ob_s = 5'h11;
        step();
        punch_signal_s = 1'b0;
        check_eq("t6_punch_sync",    32'(sync_s),    32'd1);
        check_eq("t6_punch_punched", 32'(punched_s), 32'h11);
        feed_s = 1'b0;
        step();
        check_eq("t6_punch_count", 32'(fifo_count_s), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
